// File: rtl/gshare_pkg.sv
// gshare_pkg: shared types and helpers for the gshare predictor.
// Counter encoding, saturating update and checkpoint entry.
package gshare_pkg;

  localparam int IDX_W_D = 4;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic [IDX_W_D-1:0] idx;
    logic               pred;
  } ckpt_t;

  function automatic logic [1:0] sat_next(
    input logic [1:0] cnt,
    input logic       taken
  );
    logic [1:0] n;
    n = cnt;
    unique case (1'b1)
      taken && (cnt != ST):   n = cnt + 2'd1;
      !taken && (cnt != SNT): n = cnt - 2'd1;
      default:                n = cnt;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bpred_ckpt_fifo.sv
// bpred_ckpt_fifo: in-flight prediction checkpoints.
// Flush empties the queue and beats a same-cycle push.
module bpred_ckpt_fifo
  import gshare_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 5,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr;
  logic [PTR_W-1:0]  rd;
  logic              push_ok;
  logic              pop_ok;

  assign full    = count == (PTR_W+1)'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd];

  // Entry storage; a flushed push is never written.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr] <= din;
  end

  // Pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else if (flush) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr <= wr + 1'b1;
      if (pop_ok)  rd <= rd + 1'b1;
      count <= count
             + {{PTR_W{1'b0}}, push_ok}
             - {{PTR_W{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/gshare_ctrl.sv
// gshare_ctrl: gshare predictor with speculative GHR,
// checkpoint FIFO and mispredict repair.
module gshare_ctrl
  import gshare_pkg::*;
#(
  parameter int IDX_W  = IDX_W_D,
  parameter int HIST_W = 4,
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_valid,
  input  logic [PC_W-1:0]        pred_pc,
  output logic                   pred_ready,
  output logic                   prediction,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   res_ready,
  output logic                   mispredict,
  output logic [$clog2(DEPTH):0] inflight
);

  logic [1:0]        tbl [2**IDX_W];
  logic [HIST_W-1:0] ghr_spec;
  logic [HIST_W-1:0] ghr_commit;
  logic [HIST_W-1:0] spec_nxt;
  logic [HIST_W-1:0] commit_nxt;
  logic [IDX_W-1:0]  ghr_ext;
  logic [IDX_W-1:0]  idx;
  ckpt_t             push_d;
  ckpt_t             head;
  logic              full;
  logic              empty;
  logic              pred_acc;
  logic              res_acc;
  logic              mis;

  // Hash the PC word index with the speculative history.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_W-1:0] = ghr_spec;
    idx = pred_pc[IDX_W+1:2] ^ ghr_ext;
  end

  // Next history values: shift in the newest outcome.
  always_comb begin
    spec_nxt      = ghr_spec << 1;
    spec_nxt[0]   = prediction;
    commit_nxt    = ghr_commit << 1;
    commit_nxt[0] = res_taken;
  end

  assign prediction = tbl[idx][1];
  assign pred_ready = !full;
  assign res_ready  = !empty;
  assign pred_acc   = pred_valid && pred_ready;
  assign res_acc    = res_valid && res_ready;
  assign mis        = res_acc && (res_taken != head.pred);
  assign push_d     = '{idx: idx, pred: prediction};

  bpred_ckpt_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W ($bits(ckpt_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pred_acc),
    .pop   (res_acc),
    .flush (mis),
    .din   (push_d),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (inflight)
  );

  // Train the counter of the resolving branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= SNT;
    end else if (res_acc) begin
      tbl[head.idx] <= sat_next(tbl[head.idx], res_taken);
    end
  end

  // Histories; a mispredict rebuilds spec from commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_spec   <= '0;
      ghr_commit <= '0;
      mispredict <= 1'b0;
    end else begin
      mispredict <= mis;
      if (res_acc) ghr_commit <= commit_nxt;
      if (mis)
        ghr_spec <= commit_nxt;
      else if (pred_acc)
        ghr_spec <= spec_nxt;
    end
  end

endmodule
